// File: rtl/csr_trap_if.sv
// Decode/execute-side bus of the machine-mode CSR and trap unit.
// i_csr_en/i_mret qualify one instruction per cycle (no backpressure); o_redirect is a one-cycle pulse and o_redirect_pc is valid only while it is high.
interface csr_trap_if;
  logic        i_csr_en;
  logic [2:0]  i_csr_op;
  logic [11:0] i_csr_addr;
  logic [4:0]  i_rs1_idx;
  logic [31:0] i_rs1_data;
  logic        i_mret;
  logic [31:0] i_pc_next;
  logic [31:0] o_csr_rdata;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic [1:0]  o_dbg_state;

  modport master (
    output i_csr_en, i_csr_op, i_csr_addr, i_rs1_idx, i_rs1_data, i_mret, i_pc_next,
    input  o_csr_rdata, o_redirect, o_redirect_pc, o_dbg_state
  );

  modport slave (
    input  i_csr_en, i_csr_op, i_csr_addr, i_rs1_idx, i_rs1_data, i_mret, i_pc_next,
    output o_csr_rdata, o_redirect, o_redirect_pc, o_dbg_state
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file plus interrupt entry / mret sequencer for the RV32I pipeline.
// Interrupt lines are synchronised; entry and return each issue a one-cycle redirect.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        i_clk,
  input logic        i_rst,
  input logic        i_irq_ext,
  input logic        i_irq_timer,
  csr_trap_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                   r_mie_bit;
  logic                   r_mpie;
  logic                   r_mtie;
  logic                   r_meie;
  logic [31:0]            r_mtvec;
  logic [31:0]            r_mepc;
  logic [31:0]            r_mcause;
  logic [SYNC_STAGES-1:0] r_sync_ext;
  logic [SYNC_STAGES-1:0] r_sync_tim;

  logic        w_meip;
  logic        w_mtip;
  logic [31:0] w_mstatus;
  logic [31:0] w_mie_reg;
  logic [31:0] w_mip;
  logic [31:0] w_rdata;
  logic [31:0] w_src;
  logic [31:0] w_wdata;
  logic        w_wr_en;
  logic        w_idle;
  logic        w_do_mret;
  logic        w_do_csr;
  logic        w_take;
  logic [31:0] w_cause;
  logic [31:0] w_trap_base;
  logic [31:0] w_trap_target;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  assign w_meip    = r_sync_ext[SYNC_STAGES-1];
  assign w_mtip    = r_sync_tim[SYNC_STAGES-1];
  assign w_mstatus = {24'b0, r_mpie, 3'b0, r_mie_bit, 3'b0};
  assign w_mie_reg = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
  assign w_mip     = {20'b0, w_meip, 3'b0, w_mtip, 7'b0};

  always_comb begin
    w_rdata = '0;
    case (bus.i_csr_addr)
      12'h300: w_rdata = w_mstatus;
      12'h304: w_rdata = w_mie_reg;
      12'h305: w_rdata = r_mtvec;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h344: w_rdata = w_mip;
      default: w_rdata = '0;
    endcase
  end

  // op[2] selects the zero-extended rs1 field as the operand.
  assign w_src = bus.i_csr_op[2] ? {27'b0, bus.i_rs1_idx} : bus.i_rs1_data;

  always_comb begin
    w_wdata = w_rdata;
    w_wr_en = 1'b0;
    case (bus.i_csr_op[1:0])
      2'b01: begin
        w_wdata = w_src;
        w_wr_en = 1'b1;
      end
      2'b10: begin
        w_wdata = w_rdata | w_src;
        w_wr_en = (bus.i_rs1_idx != 5'd0);
      end
      2'b11: begin
        w_wdata = w_rdata & ~w_src;
        w_wr_en = (bus.i_rs1_idx != 5'd0);
      end
      default: ;
    endcase
  end

  assign w_idle    = (r_state == ST_IDLE);
  assign w_do_mret = w_idle & bus.i_mret;
  assign w_do_csr  = w_idle & ~bus.i_mret & bus.i_csr_en & w_wr_en;
  assign w_take    = w_idle & r_mie_bit & (|(w_mip & w_mie_reg)) & ~bus.i_csr_en & ~bus.i_mret;
  assign w_cause   = (w_meip & r_meie) ? 32'h8000_000B : 32'h8000_0007;

  // Vectored mode offsets by 4*code; the code is the low bits of the latched mcause.
  assign w_trap_base   = {r_mtvec[31:2], 2'b00};
  assign w_trap_target = (r_mtvec[1:0] == 2'b01) ? (w_trap_base + {r_mcause[29:0], 2'b00})
                                                 : w_trap_base;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync_ext <= '0;
      r_sync_tim <= '0;
    end else begin
      r_sync_ext <= {r_sync_ext[SYNC_STAGES-2:0], i_irq_ext};
      r_sync_tim <= {r_sync_tim[SYNC_STAGES-2:0], i_irq_timer};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_mret)  w_state_next = ST_RET;
        else if (w_take) w_state_next = ST_TRAP;
      end
      ST_TRAP: begin
        w_redirect    = 1'b1;
        w_redirect_pc = w_trap_target;
        w_state_next  = ST_IDLE;
      end
      ST_RET: begin
        w_redirect    = 1'b1;
        w_redirect_pc = r_mepc;
        w_state_next  = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mie_bit <= 1'b0;
      r_mpie    <= 1'b0;
      r_mtie    <= 1'b0;
      r_meie    <= 1'b0;
      r_mtvec   <= MTVEC_RESET;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (w_do_mret) begin
      r_mie_bit <= r_mpie;
      r_mpie    <= 1'b1;
    end else if (w_do_csr) begin
      case (bus.i_csr_addr)
        12'h300: begin
          r_mie_bit <= w_wdata[3];
          r_mpie    <= w_wdata[7];
        end
        12'h304: begin
          r_mtie <= w_wdata[7];
          r_meie <= w_wdata[11];
        end
        12'h305: r_mtvec  <= w_wdata[1] ? (w_wdata & ~32'h3) : w_wdata;
        12'h341: r_mepc   <= w_wdata & ~32'h3;
        12'h342: r_mcause <= w_wdata;
        default: ;
      endcase
    end else if (w_take) begin
      r_mepc    <= bus.i_pc_next & ~32'h3;
      r_mcause  <= w_cause;
      r_mpie    <= r_mie_bit;
      r_mie_bit <= 1'b0;
    end
  end

  assign bus.o_csr_rdata   = w_rdata;
  assign bus.o_redirect    = w_redirect;
  assign bus.o_redirect_pc = w_redirect_pc;
  assign bus.o_dbg_state   = r_state;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed walk through CSR access, trap entry and mret,
// then randomized traffic compared every cycle against a behavioural model.
module tb_csr_trap_unit;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic irq_ext;
  logic irq_timer;

  always #5 clk = ~clk;

  csr_trap_if bus();

  csr_trap_unit #(.MTVEC_RESET(32'h0000_0100), .SYNC_STAGES(SYNC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_irq_ext   (irq_ext),
    .i_irq_timer (irq_timer),
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: plain CSR values, a delay line per interrupt line and the pending redirect target.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
  logic        ext_q[$];
  logic        tim_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mstatus = 32'h0;
    m_mie     = 32'h0;
    m_mtvec   = 32'h100;
    m_mepc    = 32'h0;
    m_mcause  = 32'h0;
    ext_q.delete();
    tim_q.delete();
    for (int i = 0; i < SYNC; i++) begin
      ext_q.push_back(1'b0);
      tim_q.push_back(1'b0);
    end
    exp_q.delete();
  endtask

  function automatic logic [31:0] m_mip();
    logic [31:0] v;
    v = 32'h0;
    if (ext_q[0]) v = v | 32'h800;
    if (tim_q[0]) v = v | 32'h80;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] addr);
    case (addr)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip();
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_csr_write();
    logic [31:0] old_v, src, nv;
    bit          wr;
    old_v = m_read(bus.i_csr_addr);
    src   = bus.i_csr_op[2] ? {27'b0, bus.i_rs1_idx} : bus.i_rs1_data;
    wr    = 1'b0;
    nv    = old_v;
    case (bus.i_csr_op)
      3'b001, 3'b101: begin nv = src; wr = 1'b1; end
      3'b010, 3'b110: begin nv = old_v | src; wr = (bus.i_rs1_idx != 0); end
      3'b011, 3'b111: begin nv = old_v & ~src; wr = (bus.i_rs1_idx != 0); end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      case (bus.i_csr_addr)
        12'h300: m_mstatus = nv & 32'h88;
        12'h304: m_mie     = nv & 32'h880;
        12'h305: m_mtvec   = (nv & 32'h2) != 0 ? (nv & ~32'h3) : nv;
        12'h341: m_mepc    = nv & ~32'h3;
        12'h342: m_mcause  = nv;
        default: ;
      endcase
    end
  endtask

  task automatic model_edge();
    logic [31:0] pend, code, target;
    pend = m_mip() & m_mie;
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (bus.i_mret) begin
      m_mstatus = 32'h80 | (((m_mstatus >> 7) & 32'h1) << 3);
      exp_q.push_back(m_mepc);
    end else if (bus.i_csr_en) begin
      model_csr_write();
    end else if ((m_mstatus & 32'h8) != 0 && pend != 0) begin
      code     = (pend & 32'h800) != 0 ? 32'd11 : 32'd7;
      m_mepc   = bus.i_pc_next & ~32'h3;
      m_mcause = 32'h8000_0000 | code;
      m_mstatus = 32'h80;
      target   = m_mtvec & ~32'h3;
      if ((m_mtvec & 32'h3) == 32'h1) target = target + 4 * code;
      exp_q.push_back(target);
    end
    ext_q.push_back(irq_ext);
    void'(ext_q.pop_front());
    tim_q.push_back(irq_timer);
    void'(tim_q.pop_front());
  endtask

  task automatic compare_model();
    chk("rdata", bus.o_csr_rdata, m_read(bus.i_csr_addr));
    chk("redirect", {31'b0, bus.o_redirect}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    chk("redirect_pc", bus.o_redirect_pc, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1 compare_model();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [11:0] addr, input logic [31:0] exp);
    bus.i_csr_addr = addr;
    #1 chk(name, bus.o_csr_rdata, exp);
    cycle();
  endtask

  task automatic csr_w(input string name, input logic [2:0] op, input logic [11:0] addr,
                       input logic [4:0] idx, input logic [31:0] data, input logic [31:0] exp_old);
    bus.i_csr_en   = 1'b1;
    bus.i_csr_op   = op;
    bus.i_csr_addr = addr;
    bus.i_rs1_idx  = idx;
    bus.i_rs1_data = data;
    #1 chk(name, bus.o_csr_rdata, exp_old);
    cycle();
    bus.i_csr_en = 1'b0;
    bus.i_csr_op = 3'b000;
  endtask

  initial begin
    rst            = 1'b1;
    irq_ext        = 1'b0;
    irq_timer      = 1'b0;
    bus.i_csr_en   = 1'b0;
    bus.i_csr_op   = 3'b000;
    bus.i_csr_addr = 12'h000;
    bus.i_rs1_idx  = 5'd0;
    bus.i_rs1_data = 32'h0;
    bus.i_mret     = 1'b0;
    bus.i_pc_next  = 32'h40;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    lit("rst_mtvec", 12'h305, 32'h100);
    lit("rst_mstatus", 12'h300, 32'h0);
    lit("rst_mie", 12'h304, 32'h0);
    lit("rst_mip", 12'h344, 32'h0);

    csr_w("csrrw_mie_old", 3'b001, 12'h304, 5'd1, 32'h880, 32'h0);
    lit("mie_readback", 12'h304, 32'h880);
    csr_w("csrrci_zero_old", 3'b111, 12'h304, 5'd0, 32'hFFFF_FFFF, 32'h880);
    lit("mie_unchanged", 12'h304, 32'h880);
    csr_w("csrrs_mstatus_old", 3'b010, 12'h300, 5'd2, 32'h8, 32'h0);
    lit("mstatus_mie_set", 12'h300, 32'h8);

    // External interrupt: two synchroniser edges, then one edge into the trap.
    irq_ext = 1'b1;
    bus.i_csr_addr = 12'h344;
    cycle();
    cycle();
    #1 chk("mip_meip", bus.o_csr_rdata, 32'h800);
    chk("no_redirect_yet", {31'b0, bus.o_redirect}, 32'd0);
    cycle();
    #1 chk("trap_redirect", {31'b0, bus.o_redirect}, 32'd1);
    chk("trap_pc_direct", bus.o_redirect_pc, 32'h100);
    cycle();
    lit("trap_mepc", 12'h341, 32'h40);
    lit("trap_mcause", 12'h342, 32'h8000_000B);
    lit("trap_mstatus", 12'h300, 32'h80);

    bus.i_mret = 1'b1;
    cycle();
    bus.i_mret = 1'b0;
    #1 chk("ret_redirect", {31'b0, bus.o_redirect}, 32'd1);
    chk("ret_pc", bus.o_redirect_pc, 32'h40);
    bus.i_csr_addr = 12'h300;
    #1 chk("ret_mstatus", bus.o_csr_rdata, 32'h88);
    cycle();
    cycle();
    #1 chk("retrap_redirect", {31'b0, bus.o_redirect}, 32'd1);
    chk("retrap_pc", bus.o_redirect_pc, 32'h100);
    cycle();

    // Vectored mode with both lines pending, then timer only.
    irq_timer = 1'b1;
    csr_w("csrrw_mtvec_old", 3'b001, 12'h305, 5'd1, 32'h201, 32'h100);
    csr_w("csrrs_mie2_old", 3'b010, 12'h300, 5'd1, 32'h8, 32'h80);
    cycle();
    #1 chk("vec_ext_pc", bus.o_redirect_pc, 32'h22C);
    cycle();
    irq_ext = 1'b0;
    lit("vec_mstatus", 12'h300, 32'h80);
    lit("vec_mcause_ext", 12'h342, 32'h8000_000B);
    lit("mip_timer_only", 12'h344, 32'h80);
    bus.i_mret = 1'b1;
    cycle();
    bus.i_mret = 1'b0;
    #1 chk("vec_ret_pc", bus.o_redirect_pc, 32'h40);
    cycle();
    cycle();
    #1 chk("vec_tim_pc", bus.o_redirect_pc, 32'h21C);
    cycle();
    lit("vec_mcause_tim", 12'h342, 32'h8000_0007);

    // CSR write clearing MIE in the cycle the interrupt becomes eligible.
    irq_timer = 1'b0;
    lit("mip_drain1", 12'h344, 32'h80);
    lit("mip_drain2", 12'h344, 32'h80);
    lit("mip_drain3", 12'h344, 32'h0);
    bus.i_mret = 1'b1;
    cycle();
    bus.i_mret = 1'b0;
    cycle();
    irq_ext = 1'b1;
    cycle();
    cycle();
    csr_w("csrrw_clr_mie_old", 3'b001, 12'h300, 5'd1, 32'h0, 32'h88);
    for (int i = 0; i < 3; i++) begin
      #1 chk("defer_no_trap", {31'b0, bus.o_redirect}, 32'd0);
      cycle();
    end

    // Reset while the trap redirect is on the bus.
    csr_w("csrrs_mie3_old", 3'b010, 12'h300, 5'd1, 32'h8, 32'h0);
    cycle();
    #1 chk("trap_before_rst", {31'b0, bus.o_redirect}, 32'd1);
    rst = 1'b1;
    model_reset();
    #1 chk("rst_in_trap_redirect", {31'b0, bus.o_redirect}, 32'd0);
    chk("rst_in_trap_pc", bus.o_redirect_pc, 32'h0);
    cycle();
    rst = 1'b0;
    irq_ext = 1'b0;
    cycle();

    for (int n = 0; n < 1500; n++) begin
      bus.i_csr_en = ($urandom_range(0, 99) < 30);
      bus.i_csr_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 6))
        0: bus.i_csr_addr = 12'h300;
        1: bus.i_csr_addr = 12'h304;
        2: bus.i_csr_addr = 12'h305;
        3: bus.i_csr_addr = 12'h341;
        4: bus.i_csr_addr = 12'h342;
        5: bus.i_csr_addr = 12'h344;
        default: bus.i_csr_addr = 12'($urandom_range(0, 4095));
      endcase
      bus.i_rs1_idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.i_rs1_data = $urandom;
      bus.i_mret     = ($urandom_range(0, 99) < 8);
      bus.i_pc_next  = $urandom;
      if ($urandom_range(0, 9) == 0) irq_ext = ~irq_ext;
      if ($urandom_range(0, 9) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      cycle();
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
